// File: rtl/instr_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_queue                                            |
// | Description : Instruction fetch front-end for the TPU core. Issues         |
// |               sequential word-address requests to instruction memory on a  |
// |               valid/ready channel and accepts in-order responses. Words    |
// |               are buffered in a prefetch FIFO and issued one per           |
// |               non-stalled cycle. NOP bubbles fill empty cycles. Supports   |
// |               start, flush/redirect and HALT (opcode 8'hFF).               |
// | Ports       : clk, rst              clock, sync active-high reset          |
// |               start, start_pc       begin fetching from IDLE/HALTED        |
// |               flush, flush_pc       discard buffered/in-flight, redirect   |
// |               stall                 core not consuming, hold output        |
// |               imem_req_*            request channel (valid/ready/addr)     |
// |               imem_rsp_*            in-order response channel              |
// |               instruction_out       registered instruction to the core    |
// |               issue_valid           instruction_out is a fetched word      |
// |               busy, halted          FETCH/DRAIN, HALTED status             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_fetch_queue #(
   parameter int          ADDR_W     = 16,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_pc,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   input  logic              stall,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   output logic [31:0]       instruction_out,
   output logic              issue_valid,
   output logic              busy,
   output logic              halted
);

   localparam int                   c_ptr_w     = $clog2(FIFO_DEPTH);
   localparam int                   c_cnt_w     = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0]   c_cnt_one   = c_cnt_w'(1);
   localparam logic [c_cnt_w:0]     c_depth_ext = (c_cnt_w + 1)'(FIFO_DEPTH);
   localparam logic [c_ptr_w-1:0]   c_ptr_one   = c_ptr_w'(1);
   localparam logic [7:0]           c_halt_op   = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_DRAIN  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t              state_q,       state_d;
   logic [ADDR_W-1:0]   pc_q,          pc_d;
   logic [c_ptr_w-1:0]  rd_ptr_q,      rd_ptr_d;
   logic [c_ptr_w-1:0]  wr_ptr_q,      wr_ptr_d;
   logic [c_cnt_w-1:0]  count_q,       count_d;
   logic [c_cnt_w-1:0]  inflight_q,    inflight_d;
   logic [c_cnt_w-1:0]  drop_q,        drop_d;
   logic [31:0]         instr_q,       instr_d;
   logic                issue_valid_q, issue_valid_d;
   logic [31:0]         fifo_mem_q [FIFO_DEPTH];

   logic flush_act, start_act, req_valid, accept;
   logic rsp_take, rsp_halt, push, pop;

   // Control decode
   always_comb begin
      flush_act = flush && (state_q == S_FETCH || state_q == S_DRAIN);
      start_act = start && !flush && (state_q == S_IDLE || state_q == S_HALTED);
      // Credit: outstanding plus buffered words never exceed the FIFO size,
      // so every response has a guaranteed slot.
      req_valid = (state_q == S_FETCH) && !flush &&
                  (({1'b0, inflight_q} + {1'b0, count_q}) < c_depth_ext);
      accept    = req_valid && imem_req_ready;
      rsp_take  = imem_rsp_valid && (inflight_q != '0);
      rsp_halt  = rsp_take && (drop_q == '0) && !flush_act &&
                  (imem_rsp_data[31:24] == c_halt_op);
      push      = rsp_take && (drop_q == '0) && !flush_act &&
                  (imem_rsp_data[31:24] != c_halt_op);
      pop       = !stall && !flush_act && (count_q != '0);
   end

   // Next-state computation
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      inflight_d    = inflight_q;
      drop_d        = drop_q;
      instr_d       = instr_q;
      issue_valid_d = issue_valid_q;

      if (accept && !rsp_take) begin
         inflight_d = inflight_q + c_cnt_one;
      end else if (!accept && rsp_take) begin
         inflight_d = inflight_q - c_cnt_one;
      end

      if (flush_act) begin
         // Every response still owed (after this cycle's one) is stale.
         drop_d = inflight_d;
      end else if (rsp_take && drop_q != '0) begin
         drop_d = drop_q - c_cnt_one;
      end else if (rsp_halt) begin
         // Younger responses, including a request accepted this very cycle,
         // belong to the dead path behind the HALT.
         drop_d = inflight_d;
      end

      if (flush_act) begin
         pc_d = flush_pc;
      end else if (start_act) begin
         pc_d = start_pc;
      end else if (accept) begin
         pc_d = pc_q + 1'b1;
      end

      if (flush_act) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + c_ptr_one;
         if (pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
         if (push && !pop) begin
            count_d = count_q + c_cnt_one;
         end else if (!push && pop) begin
            count_d = count_q - c_cnt_one;
         end
      end

      if (flush_act) begin
         instr_d       = NOP_WORD;
         issue_valid_d = 1'b0;
      end else if (!stall) begin
         instr_d       = pop ? fifo_mem_q[rd_ptr_q] : NOP_WORD;
         issue_valid_d = pop;
      end

      if (flush_act) begin
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_IDLE, S_HALTED: if (start_act) state_d = S_FETCH;
            S_FETCH:          if (rsp_halt)  state_d = S_DRAIN;
            S_DRAIN:          if (count_q == '0 && inflight_q == drop_q) state_d = S_HALTED;
            default:          state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         inflight_q    <= '0;
         drop_q        <= '0;
         instr_q       <= NOP_WORD;
         issue_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         drop_q        <= drop_d;
         instr_q       <= instr_d;
         issue_valid_q <= issue_valid_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers/count.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         fifo_mem_q[wr_ptr_q] <= imem_rsp_data;
      end
   end

   assign imem_req_valid  = req_valid;
   assign imem_req_addr   = pc_q;
   assign instruction_out = instr_q;
   assign issue_valid     = issue_valid_q;
   assign busy            = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign halted          = (state_q == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch_queue                                         |
// | Description : Self-checking bench for instr_fetch_queue. A memory agent    |
// |               serves requests with configurable latency and a scoreboard   |
// |               predicts the issued instruction stream cycle by cycle.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_queue;

   localparam int          ADDR_W     = 16;
   localparam int          FIFO_DEPTH = 4;
   localparam logic [31:0] NOP        = 32'h0000_0000;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] start_pc;
   logic              flush;
   logic [ADDR_W-1:0] flush_pc;
   logic              stall;
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [31:0]       imem_rsp_data;
   logic [31:0]       instruction_out;
   logic              issue_valid;
   logic              busy;
   logic              halted;

   always #5 clk = ~clk;

   instr_fetch_queue #(
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .NOP_WORD   (NOP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .start_pc        (start_pc),
      .flush           (flush),
      .flush_pc        (flush_pc),
      .stall           (stall),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .instruction_out (instruction_out),
      .issue_valid     (issue_valid),
      .busy            (busy),
      .halted          (halted)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      int                due;
      bit                drop;
   } pend_t;

   typedef struct {
      logic [31:0] word;
      int          ready;
   } exp_t;

   pend_t       pend_q[$];
   exp_t        sb_q[$];
   logic [31:0] mem [logic [ADDR_W-1:0]];

   int n_checks = 0;
   int n_pass   = 0;
   int edge_k   = 0;
   int lat      = 1;
   int acc_count = 0;
   bit rand_ready = 1'b0;
   bit fetching   = 1'b0;
   logic [ADDR_W-1:0] tb_pc   = '0;
   logic [31:0]       exp_out = NOP;
   logic              exp_iv  = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
      if (mem.exists(a)) return mem[a];
      return {8'h10, 8'h00, a};
   endfunction

   // Memory agent and scoreboard. At negedge+1 the outputs reflect the last
   // posedge and all inputs for the next posedge (edge_k) are settled.
   initial begin : agent
      pend_t p;
      exp_t  e;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_req_ready = 1'b1;
      forever begin
         @(negedge clk);
         #1;
         if (edge_k > 0) begin
            check_eq("instruction_out", instruction_out, exp_out);
            check_eq("issue_valid", {31'b0, issue_valid}, {31'b0, exp_iv});
         end
         imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (rst) begin
            pend_q.delete();
            sb_q.delete();
            fetching       = 1'b0;
            tb_pc          = '0;
            exp_out        = NOP;
            exp_iv         = 1'b0;
            imem_rsp_valid = 1'b0;
         end else begin
            // Issue prediction for this edge
            if (flush && fetching) begin
               exp_out = NOP;
               exp_iv  = 1'b0;
            end else if (!stall) begin
               if (sb_q.size() > 0 && sb_q[0].ready <= edge_k) begin
                  exp_out = sb_q[0].word;
                  exp_iv  = 1'b1;
                  void'(sb_q.pop_front());
               end else begin
                  exp_out = NOP;
                  exp_iv  = 1'b0;
               end
            end
            if (start && !flush && !fetching) begin
               fetching = 1'b1;
               tb_pc    = start_pc;
            end
            if (flush && fetching) begin
               foreach (pend_q[i]) pend_q[i].drop = 1'b1;
               sb_q.delete();
               tb_pc = flush_pc;
            end
            if (imem_req_valid && imem_req_ready) begin
               check_eq("req_addr", {16'b0, imem_req_addr}, {16'b0, tb_pc});
               p.addr = tb_pc;
               p.due  = edge_k + lat;
               p.drop = 1'b0;
               pend_q.push_back(p);
               tb_pc = tb_pc + 1'b1;
               acc_count++;
            end
            if (pend_q.size() > 0 && pend_q[0].due <= edge_k) begin
               p = pend_q.pop_front();
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(p.addr);
               if (!p.drop) begin
                  if (imem_rsp_data[31:24] == 8'hFF) begin
                     foreach (pend_q[i]) pend_q[i].drop = 1'b1;
                  end else begin
                     e.word  = imem_rsp_data;
                     e.ready = edge_k + 1;
                     sb_q.push_back(e);
                  end
               end
            end else begin
               imem_rsp_valid = 1'b0;
               imem_rsp_data  = $urandom();
            end
         end
         edge_k++;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_instr"}, instruction_out, NOP);
      check_eq({tag, "_iv"},    {31'b0, issue_valid},    32'd0);
      check_eq({tag, "_reqv"},  {31'b0, imem_req_valid}, 32'd0);
      check_eq({tag, "_addr"},  {16'b0, imem_req_addr},  32'd0);
      check_eq({tag, "_busy"},  {31'b0, busy},           32'd0);
      check_eq({tag, "_halt"},  {31'b0, halted},         32'd0);
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] pc);
      start    = 1'b1;
      start_pc = pc;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin : main
      int waited;
      rst = 1'b1; start = 1'b0; start_pc = '0; flush = 1'b0; flush_pc = '0; stall = 1'b0;
      mem[16'h0100] = 32'h0300_0001;
      mem[16'h0101] = 32'h0500_0002;
      mem[16'h0400] = 32'h0600_0003;
      mem[16'h0401] = 32'hFF00_0000;
      mem[16'h0402] = 32'h0700_0004;
      mem[16'h0200] = 32'h0A00_0200;
      cycles(3);
      rst = 1'b0;
      @(negedge clk); #2;
      check_reset_outputs("reset");

      // Basic sequential fetch, latency 1
      lat = 1;
      do_start(16'h0100);
      #2 check_eq("start_busy", {31'b0, busy}, 32'd1);
      cycles(10);

      // Backpressure: stall from the start, credits cap at FIFO_DEPTH
      do_reset();
      stall = 1'b1;
      acc_count = 0;
      do_start(16'h0100);
      cycles(10);
      #2;
      check_eq("bp_accepts", acc_count, FIFO_DEPTH);
      check_eq("bp_reqv", {31'b0, imem_req_valid}, 32'd0);
      stall = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         @(negedge clk); #2;
         check_eq("bp_b2b", {31'b0, issue_valid}, 32'd1);
      end
      cycles(4);

      // HALT in the response stream
      do_reset();
      do_start(16'h0400);
      waited = 0;
      while (!halted && waited < 30) begin
         @(negedge clk); #2;
         waited++;
      end
      check_eq("halt_reached", {31'b0, halted}, 32'd1);
      check_eq("halt_busy", {31'b0, busy}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #2;
         check_eq("halt_noreq", {31'b0, imem_req_valid}, 32'd0);
      end

      // Flush with words in flight and buffered
      do_reset();
      lat   = 3;
      stall = 1'b1;
      do_start(16'h0500);
      cycles(5);
      flush    = 1'b1;
      flush_pc = 16'h0200;
      @(negedge clk);
      flush = 1'b0;
      stall = 1'b0;
      #2;
      check_eq("flush_nop", instruction_out, NOP);
      check_eq("flush_iv", {31'b0, issue_valid}, 32'd0);
      waited = 0;
      while (!issue_valid && waited < 20) begin
         @(negedge clk); #2;
         waited++;
      end
      check_eq("flush_first", instruction_out, mem_word(16'h0200));
      cycles(6);

      // PC wrap with random ready
      do_reset();
      lat = 1;
      rand_ready = 1'b1;
      do_start(16'hFFFF);
      cycles(14);
      rand_ready = 1'b0;

      // Reset in the middle of a stalled fetch, then restart
      do_reset();
      stall = 1'b1;
      do_start(16'h0100);
      cycles(3);
      do_reset();
      #2;
      check_reset_outputs("midrst");
      stall = 1'b0;
      do_start(16'h0100);
      cycles(10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
